// File: rtl/instruction_decode_if.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_decode_if
//  Description : Bus bundle between the fetch/EX/WB side and the decode stage.
//                master = upstream driver (fetch, EX, WB, pipeline control)
//                slave  = instruction_decode
//                Inputs to decode : en, flush, fetchBuffer, wbEn/wbReg/wbData,
//                                   exMemRead, exRd
//                Outputs of decode: stallOut, valid, opcode, rd, rsData1/2,
//                                   imm, pcOut, control bits, halted, illegal
//  Revision    : 1.0  initial release
// ============================================================================
interface instruction_decode_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  en;
  logic                  flush;
  logic [55:0]           fetchBuffer;
  logic                  wbEn;
  logic [3:0]            wbReg;
  logic [DATA_WIDTH-1:0] wbData;
  logic                  exMemRead;
  logic [3:0]            exRd;

  logic                  stallOut;
  logic                  valid;
  logic [3:0]            opcode;
  logic [3:0]            rd;
  logic [DATA_WIDTH-1:0] rsData1;
  logic [DATA_WIDTH-1:0] rsData2;
  logic [DATA_WIDTH-1:0] imm;
  logic [23:0]           pcOut;
  logic                  regWrite;
  logic                  memRead;
  logic                  memWrite;
  logic                  isBranch;
  logic                  isJump;
  logic                  aluSrcImm;
  logic                  halted;
  logic                  illegal;

  modport master (
    output en, flush, fetchBuffer, wbEn, wbReg, wbData, exMemRead, exRd,
    input  stallOut, valid, opcode, rd, rsData1, rsData2, imm, pcOut,
           regWrite, memRead, memWrite, isBranch, isJump, aluSrcImm,
           halted, illegal
  );

  modport slave (
    input  en, flush, fetchBuffer, wbEn, wbReg, wbData, exMemRead, exRd,
    output stallOut, valid, opcode, rd, rsData1, rsData2, imm, pcOut,
           regWrite, memRead, memWrite, isBranch, isJump, aluSrcImm,
           halted, illegal
  );
endinterface
`default_nettype wire

// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_decode
//  Description : Decode stage. Reads a 16x32 register file (r0 hardwired 0,
//                write-through bypass from WB), decodes control, detects
//                load-use hazards and registers the decode/execute buffer.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-low reset
//                bus  - instruction_decode_if.slave (see interface header)
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_decode #(
  parameter int REG_COUNT  = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  instruction_decode_if.slave   bus
);

  localparam logic [3:0] OP_ALU_RR = 4'd1;
  localparam logic [3:0] OP_ALU_I  = 4'd2;
  localparam logic [3:0] OP_LOAD   = 4'd3;
  localparam logic [3:0] OP_STORE  = 4'd4;
  localparam logic [3:0] OP_BRANCH = 4'd5;
  localparam logic [3:0] OP_JUMP   = 4'd6;
  localparam logic [3:0] OP_HALT   = 4'd7;

  // control vector order: {regWrite, memRead, memWrite, isBranch, isJump, aluSrcImm}
  logic [DATA_WIDTH-1:0] rf_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] rf_d [REG_COUNT];
  logic                  valid_q,   valid_d;
  logic [3:0]            opcode_q,  opcode_d;
  logic [3:0]            rd_q,      rd_d;
  logic [DATA_WIDTH-1:0] rs1_q,     rs1_d;
  logic [DATA_WIDTH-1:0] rs2_q,     rs2_d;
  logic [DATA_WIDTH-1:0] imm_q,     imm_d;
  logic [23:0]           pc_q,      pc_d;
  logic [5:0]            ctrl_q,    ctrl_d;
  logic                  halted_q,  halted_d;
  logic                  illegal_q, illegal_d;

  logic [31:0]           w_instr;
  logic [3:0]            w_op, w_rd, w_rs1, w_rs2;
  logic [DATA_WIDTH-1:0] w_rs1_data, w_rs2_data, w_imm;
  logic [5:0]            w_ctrl;
  logic                  w_use_rs1, w_use_rs2, w_hazard;

  assign w_instr = bus.fetchBuffer[55:24];
  assign w_op    = w_instr[31:28];
  assign w_rd    = w_instr[27:24];
  assign w_rs1   = w_instr[23:20];
  assign w_rs2   = w_instr[19:16];
  assign w_imm   = {{(DATA_WIDTH-16){w_instr[15]}}, w_instr[15:0]};

  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_ctrl    = 6'b000000;
    case (w_op)
      OP_ALU_RR: begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_ctrl = 6'b100000; end
      OP_ALU_I:  begin w_use_rs1 = 1'b1;                   w_ctrl = 6'b100001; end
      OP_LOAD:   begin w_use_rs1 = 1'b1;                   w_ctrl = 6'b110001; end
      OP_STORE:  begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_ctrl = 6'b001001; end
      OP_BRANCH: begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_ctrl = 6'b000100; end
      OP_JUMP:   begin                                     w_ctrl = 6'b000011; end
      default:   begin end
    endcase
  end

  // Same-cycle write-back is forwarded so the decoded operand is never stale.
  always_comb begin
    w_rs1_data = '0;
    w_rs2_data = '0;
    if (w_rs1 != 4'd0)
      w_rs1_data = (bus.wbEn && bus.wbReg == w_rs1) ? bus.wbData : rf_q[w_rs1];
    if (w_rs2 != 4'd0)
      w_rs2_data = (bus.wbEn && bus.wbReg == w_rs2) ? bus.wbData : rf_q[w_rs2];
  end

  assign w_hazard = bus.en && !bus.flush && !halted_q && bus.exMemRead &&
                    (bus.exRd != 4'd0) &&
                    ((w_use_rs1 && bus.exRd == w_rs1) || (w_use_rs2 && bus.exRd == w_rs2));

  // Once halted, fetch is frozen permanently until reset.
  assign bus.stallOut = halted_q || w_hazard;

  // Write-back ignores en/stall/flush/halted; r0 is never written.
  always_comb begin
    rf_d = rf_q;
    if (bus.wbEn && bus.wbReg != 4'd0)
      rf_d[bus.wbReg] = bus.wbData;
  end

  always_comb begin
    valid_d   = valid_q;
    opcode_d  = opcode_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    ctrl_d    = ctrl_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    if (bus.en) begin
      // Start from a fully zeroed bubble; only a normal issue fills it in.
      valid_d  = 1'b0;
      opcode_d = '0;
      rd_d     = '0;
      rs1_d    = '0;
      rs2_d    = '0;
      imm_d    = '0;
      pc_d     = '0;
      ctrl_d   = '0;
      if (bus.flush || halted_q || w_hazard) begin
        // bubble
      end else if (w_op[3]) begin
        illegal_d = 1'b1;
      end else if (w_op == OP_HALT) begin
        halted_d = 1'b1;
      end else begin
        valid_d  = 1'b1;
        opcode_d = w_op;
        rd_d     = w_rd;
        rs1_d    = w_rs1_data;
        rs2_d    = w_rs2_data;
        imm_d    = w_imm;
        pc_d     = bus.fetchBuffer[23:0];
        ctrl_d   = w_ctrl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      ctrl_q    <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      rf_q      <= rf_d;
      valid_q   <= valid_d;
      opcode_q  <= opcode_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
      ctrl_q    <= ctrl_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.valid     = valid_q;
  assign bus.opcode    = opcode_q;
  assign bus.rd        = rd_q;
  assign bus.rsData1   = rs1_q;
  assign bus.rsData2   = rs2_q;
  assign bus.imm       = imm_q;
  assign bus.pcOut     = pc_q;
  assign bus.regWrite  = ctrl_q[5];
  assign bus.memRead   = ctrl_q[4];
  assign bus.memWrite  = ctrl_q[3];
  assign bus.isBranch  = ctrl_q[2];
  assign bus.isJump    = ctrl_q[1];
  assign bus.aluSrcImm = ctrl_q[0];
  assign bus.halted    = halted_q;
  assign bus.illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_decode
//  Description : Self-checking bench for instruction_decode. Directed cases
//                followed by randomized traffic, compared against an
//                instruction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_decode;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instruction_decode_if #(.DATA_WIDTH(32)) bus ();

  instruction_decode #(.REG_COUNT(16), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_rf [16];
  logic        m_valid, m_halted, m_illegal;
  logic [3:0]  m_op, m_rd;
  logic [31:0] m_r1, m_r2, m_imm;
  logic [23:0] m_pc;
  logic [5:0]  m_ctrl;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {regWrite, memRead, memWrite, isBranch, isJump, aluSrcImm}
  function automatic logic [5:0] ctrl_of(input logic [3:0] op);
    case (op)
      4'd1: return 6'b100000;
      4'd2: return 6'b100001;
      4'd3: return 6'b110001;
      4'd4: return 6'b001001;
      4'd5: return 6'b000100;
      4'd6: return 6'b000011;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic bit reads_rs1(input logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd5);
  endfunction

  function automatic bit reads_rs2(input logic [3:0] op);
    return (op == 4'd1 || op == 4'd4 || op == 4'd5);
  endfunction

  function automatic logic [55:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] s1, input logic [3:0] s2,
                                     input logic [15:0] i16, input logic [23:0] pc);
    return {op, rd, s1, s2, i16, pc};
  endfunction

  task automatic set_idle();
    bus.en = 1'b1; bus.flush = 1'b0; bus.fetchBuffer = '0;
    bus.wbEn = 1'b0; bus.wbReg = '0; bus.wbData = '0;
    bus.exMemRead = 1'b0; bus.exRd = '0;
  endtask

  task automatic model_bubble();
    m_valid = 0; m_op = 0; m_rd = 0; m_r1 = 0; m_r2 = 0; m_imm = 0; m_pc = 0; m_ctrl = 0;
  endtask

  task automatic compare_outputs(input string ctx);
    check({ctx, ".valid"},   bus.valid, m_valid);
    check({ctx, ".ctrl"},    {bus.regWrite, bus.memRead, bus.memWrite,
                              bus.isBranch, bus.isJump, bus.aluSrcImm}, m_ctrl);
    check({ctx, ".halted"},  bus.halted, m_halted);
    check({ctx, ".illegal"}, bus.illegal, m_illegal);
    if (m_valid) begin
      check({ctx, ".opcode"}, bus.opcode, m_op);
      check({ctx, ".rd"},     bus.rd, m_rd);
      check({ctx, ".pcOut"},  bus.pcOut, m_pc);
      check({ctx, ".imm"},    bus.imm, m_imm);
      if (reads_rs1(m_op)) check({ctx, ".rsData1"}, bus.rsData1, m_r1);
      if (reads_rs2(m_op)) check({ctx, ".rsData2"}, bus.rsData2, m_r2);
    end
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b0;
    #2;
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    model_bubble();
    m_halted = 0; m_illegal = 0;
    check("rst.valid",   bus.valid, 0);
    check("rst.data",    {bus.opcode, bus.rd, bus.pcOut}, 0);
    check("rst.rsdata",  {bus.rsData1, bus.rsData2}, 0);
    check("rst.imm",     bus.imm, 0);
    check("rst.ctrl",    {bus.regWrite, bus.memRead, bus.memWrite,
                          bus.isBranch, bus.isJump, bus.aluSrcImm}, 0);
    check("rst.flags",   {bus.halted, bus.illegal}, 0);
    check("rst.stall",   bus.stallOut, 0);
    rst = 1'b1;
  endtask

  // One clock of decode: predict from the instruction-level rules, then compare.
  task automatic step(input string ctx);
    logic [3:0] op, rd, s1, s2;
    bit haz;
    op = bus.fetchBuffer[55:52];
    rd = bus.fetchBuffer[51:48];
    s1 = bus.fetchBuffer[47:44];
    s2 = bus.fetchBuffer[43:40];
    haz = bus.en && !bus.flush && !m_halted && bus.exMemRead && bus.exRd != 0 &&
          ((reads_rs1(op) && bus.exRd == s1) || (reads_rs2(op) && bus.exRd == s2));
    #1;
    check({ctx, ".stallOut"}, bus.stallOut, m_halted || haz);
    // Write-back lands first so a same-cycle read sees the new value.
    if (bus.wbEn && bus.wbReg != 0) m_rf[bus.wbReg] = bus.wbData;
    if (bus.en) begin
      if (bus.flush || m_halted || haz) begin
        model_bubble();
      end else if (op >= 8) begin
        model_bubble(); m_illegal = 1;
      end else if (op == 7) begin
        model_bubble(); m_halted = 1;
      end else begin
        m_valid = 1; m_op = op; m_rd = rd;
        m_r1 = (s1 == 0) ? 32'd0 : m_rf[s1];
        m_r2 = (s2 == 0) ? 32'd0 : m_rf[s2];
        m_imm = $signed(bus.fetchBuffer[39:24]);
        m_pc = bus.fetchBuffer[23:0];
        m_ctrl = ctrl_of(op);
      end
    end
    @(posedge clk);
    #1;
    compare_outputs(ctx);
  endtask

  initial begin
    logic [3:0] rop;
    int r;

    do_reset();

    // reset fetch buffer decodes as NOP
    step("nop0");

    // write r3 then read it
    bus.wbEn = 1; bus.wbReg = 3; bus.wbData = 32'h1234_5678;
    step("wb_r3");
    bus.wbEn = 0;
    bus.fetchBuffer = mk(4'd1, 4'd4, 4'd3, 4'd0, 16'h0000, 24'h000100);
    step("alurr");
    // same-cycle bypass
    bus.wbEn = 1; bus.wbReg = 3; bus.wbData = 32'hCAFE_BABE;
    step("bypass");
    bus.wbEn = 0;

    // sign-extended immediate
    bus.fetchBuffer = mk(4'd2, 4'd5, 4'd3, 4'd0, 16'h8001, 24'h000104);
    step("alui");
    // r0 write ignored, read back 0 (same cycle and next cycle)
    bus.wbEn = 1; bus.wbReg = 0; bus.wbData = 32'hFFFF_FFFF;
    bus.fetchBuffer = mk(4'd1, 4'd6, 4'd0, 4'd0, 16'h0000, 24'h000108);
    step("r0_same");
    bus.wbEn = 0;
    step("r0_next");

    // load-use hazard on STORE rs2
    bus.wbEn = 1; bus.wbReg = 5; bus.wbData = 32'h0000_00A5;
    step("wb_r5");
    bus.wbEn = 0;
    bus.exMemRead = 1; bus.exRd = 5;
    bus.fetchBuffer = mk(4'd4, 4'd0, 4'd1, 4'd5, 16'h0010, 24'h00010C);
    step("lu_stall");
    bus.exMemRead = 0;
    step("lu_issue");
    bus.exMemRead = 1; bus.exRd = 0;
    step("lu_rd0");
    // stall and flush together: flush wins
    bus.exRd = 5; bus.flush = 1;
    step("lu_flush");
    bus.exMemRead = 0; bus.flush = 0;

    // flushed HALT does nothing, real HALT freezes
    bus.fetchBuffer = mk(4'd7, 4'd0, 4'd0, 4'd0, 16'h0000, 24'h000110);
    bus.flush = 1;
    step("halt_flush");
    bus.flush = 0;
    step("halt");
    bus.fetchBuffer = mk(4'd1, 4'd1, 4'd3, 4'd5, 16'h0000, 24'h000114);
    step("halted1");
    step("halted2");
    do_reset();

    // illegal opcode, sticky, issue continues
    bus.fetchBuffer = mk(4'hA, 4'd1, 4'd2, 4'd3, 16'h1234, 24'h000200);
    step("illegal");
    bus.fetchBuffer = mk(4'd6, 4'd2, 4'd0, 4'd0, 16'h7FFF, 24'h000204);
    step("ill_sticky");

    // en=0 holds outputs while write-back still updates the file
    bus.en = 0;
    bus.fetchBuffer = mk(4'd3, 4'd8, 4'd7, 4'd0, 16'h0004, 24'h000208);
    bus.wbEn = 1; bus.wbReg = 7; bus.wbData = 32'h5555_AAAA;
    step("hold1");
    bus.wbEn = 0;
    step("hold2");
    step("hold3");
    bus.en = 1;
    step("after_hold");

    // randomized traffic
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 64 == 63) do_reset();
      r = $urandom_range(0, 99);
      if (r < 5)       rop = 4'(8 + $urandom_range(0, 7));
      else if (r < 7)  rop = 4'd7;
      else             rop = 4'($urandom_range(0, 6));
      bus.fetchBuffer = mk(rop, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)),
                           4'($urandom_range(0, 7)), 16'($urandom), 24'($urandom));
      bus.en        = ($urandom_range(0, 9) != 0);
      bus.flush     = ($urandom_range(0, 9) == 0);
      bus.wbEn      = ($urandom_range(0, 9) < 4);
      bus.wbReg     = 4'($urandom_range(0, 7));
      bus.wbData    = $urandom;
      bus.exMemRead = ($urandom_range(0, 9) < 3);
      bus.exRd      = 4'($urandom_range(0, 7));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
